// File: rtl/response_bus_arbiter.sv
// Round-robin arbiter for the shared response bus: one owner at a time, fair rotation.
// Defining RESP_ARB_WATCHDOG_EN adds a hold watchdog that force-releases the bus.
module response_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         breq,
  input  logic [NUM_MASTERS-1:0]         bhold,
  output logic [NUM_MASTERS-1:0]         bgnt,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           bus_busy,
  output logic                           timeout_err
);
  localparam int ID_W = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2) begin : g_bad_masters
    $error("response_bus_arbiter: NUM_MASTERS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("response_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] winner;

`ifdef RESP_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] hold_cnt;
`endif

  // Scan from farthest to nearest after `last`, so the nearest requester overwrites.
  always_comb begin
    logic [ID_W-1:0] cand;
    cand   = last;
    winner = last;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = ID_W'((int'(last) + i) % NUM_MASTERS);
      if (breq[cand]) winner = cand;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bgnt     <= '0;
      grant_id <= '0;
      bus_busy <= 1'b0;
      last     <= ID_W'(NUM_MASTERS - 1);
`ifdef RESP_ARB_WATCHDOG_EN
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      bgnt <= '0;
`ifdef RESP_ARB_WATCHDOG_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|breq) begin
            bgnt     <= NUM_MASTERS'(1) << winner;
            grant_id <= winner;
            last     <= winner;
            bus_busy <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          state <= HOLD;
`ifdef RESP_ARB_WATCHDOG_EN
          hold_cnt <= '0;
`endif
        end
        HOLD: begin
          // Only the owner's hold bit matters; a zero here releases the bus.
          if (!bhold[grant_id]) begin
            state    <= IDLE;
            bus_busy <= 1'b0;
          end
`ifdef RESP_ARB_WATCHDOG_EN
          else if (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= IDLE;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b1;
            hold_cnt    <= hold_cnt + 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state    <= IDLE;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef RESP_ARB_WATCHDOG_EN
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_response_bus_arbiter.sv
// Scoreboard bench for response_bus_arbiter: time-driven slave model pushes expected
// grants and per-cycle busy/timeout values; a monitor compares every cycle.
module tb_response_bus_arbiter;
  localparam int N    = 4;
  localparam int T    = 16;
  localparam int MAXC = 8192;
`ifdef RESP_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [N-1:0]         breq  = '0;
  logic [N-1:0]         bhold = '0;
  logic [N-1:0]         bgnt;
  logic [$clog2(N)-1:0] grant_id;
  logic                 bus_busy;
  logic                 timeout_err;

  response_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .breq(breq), .bhold(bhold),
    .bgnt(bgnt), .grant_id(grant_id), .bus_busy(bus_busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct { int c; int id; } gnt_t;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  bit           mon_en = 1'b0;
  bit           exp_busy [MAXC];
  bit           exp_tmo  [MAXC];
  gnt_t         q[$];
  logic [N-1:0] pending = '0;
  int           last = N - 1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference arbitration: first requester after the previous owner, modulo N.
  function automatic int pick(input logic [N-1:0] p, input int from);
    for (int i = 1; i <= N; i++)
      if (((p >> ((from + i) % N)) & 1) != 0) return (from + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] bit_of(input int w);
    return N'(1) << w;
  endfunction

  task automatic step();
    @(negedge clock);
  endtask

  task automatic drive_hold(input int w, input bit v, input logic [N-1:0] foreign);
    bhold = (foreign & ~bit_of(w)) | (v ? bit_of(w) : '0);
  endtask

  task automatic set_busy(input int c);
    if (c < MAXC) exp_busy[c] = 1'b1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_rst_bgnt", bgnt, 0);
    chk("async_rst_bus_busy", bus_busy, 0);
    chk("async_rst_timeout_err", timeout_err, 0);
    step();
    reset   = 1'b0;
    bhold   = '0;
    q.delete();
    last    = N - 1;
    pending = '1;
    breq    = pending;
    for (int c = cyc; c < MAXC; c++) begin
      exp_busy[c] = 1'b0;
      exp_tmo[c]  = 1'b0;
    end
    mon_en = 1'b1;
  endtask

  // Called on the falling edge of a cycle in which the bus is idle.
  task automatic run_txn(input logic [N-1:0] new_req, input int hold_len,
                         input logic [N-1:0] foreign, input int rst_at,
                         input bit rereq, input logic [N-1:0] mid_req);
    int w, k, leff, nh;
    bit tmo;
    k       = cyc;
    pending = pending | new_req;
    breq    = pending;
    bhold   = foreign;
    if (pending == '0) begin
      step();
      return;
    end
    w    = pick(pending, last);
    last = w;
    tmo  = WD && (hold_len >= T);
    leff = tmo ? T : hold_len;
    nh   = tmo ? T : hold_len + 1;
    q.push_back('{k + 1, w});
    for (int c = k + 1; c <= k + 1 + nh; c++) set_busy(c);
    if (tmo && (k + 2 + T < MAXC)) exp_tmo[k + 2 + T] = 1'b1;
    step();
    if (rst_at == 1) begin
      do_reset();
      return;
    end
    pending = (pending & ~bit_of(w)) | (mid_req & ~bit_of(w));
    breq    = pending;
    drive_hold(w, 1'b0, foreign);
    for (int i = 0; i < nh; i++) begin
      step();
      if (rst_at == 2 + i) begin
        do_reset();
        return;
      end
      drive_hold(w, i < leff, foreign);
    end
    step();
    drive_hold(w, 1'b0, foreign);
    if (rereq) pending = pending | bit_of(w);
    breq = pending;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * N && pending != '0; i++)
      run_txn('0, 1, '0, -1, 1'b0, '0);
  endtask

  // Monitor: pops expected grants when bgnt appears, checks busy/timeout every cycle.
  initial begin
    gnt_t e;
    logic [N-1:0] prev_gnt;
    prev_gnt = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!mon_en || cyc >= MAXC) begin
        prev_gnt = '0;
      end else begin
        chk("bus_busy", bus_busy, exp_busy[cyc]);
        chk("timeout_err", timeout_err, exp_tmo[cyc]);
        if (bgnt != '0) begin
          chk("bgnt_onehot", $countones(bgnt), 1);
          chk("bgnt_consecutive", prev_gnt, 0);
          if (q.size() == 0) begin
            chk("unexpected_bgnt", bgnt, 0);
          end else begin
            e = q.pop_front();
            chk("grant_cycle", cyc, e.c);
            chk("bgnt", bgnt, 1 << e.id);
            chk("grant_id", grant_id, e.id);
          end
        end else if (q.size() > 0 && q[0].c <= cyc) begin
          chk("missing_bgnt", bgnt, 1 << q[0].id);
          void'(q.pop_front());
        end
        prev_gnt = bgnt;
      end
    end
  end

  initial begin
    logic [N-1:0] nr, fr, mr;
    int hl, r;
    #1 reset = 1'b1;
    #1;
    chk("reset_bgnt", bgnt, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_bus_busy", bus_busy, 0);
    chk("reset_timeout_err", timeout_err, 0);
    repeat (3) @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) run_txn('0, 0, '0, -1, 1'b0, '0);

    // All four requesting after reset: 0,1,2,3,0 four cycles apart.
    repeat (5) run_txn(4'b1111, 1, '0, -1, 1'b1, '0);
    drain();
    run_txn(4'b0100, 1, '0, -1, 1'b0, '0);
    run_txn('0, 0, '0, -1, 1'b0, '0);
    // Long hold by slave 1 while slave 3 waits.
    run_txn(4'b0010, 8, '0, -1, 1'b0, 4'b1000);
    run_txn('0, 1, '0, -1, 1'b0, '0);
    // Zero-length transfer with a foreign hold on bit 0.
    run_txn(4'b0100, 0, 4'b0001, -1, 1'b0, '0);
    // Asynchronous reset mid-HOLD, then mid-GRANT.
    run_txn(4'b1000, 5, '0, 3, 1'b0, '0);
    drain();
    run_txn(4'b0010, 2, '0, 1, 1'b0, '0);
    drain();
    // Indefinite hold: watchdog release when enabled, honoured otherwise.
    run_txn(4'b0001, 24, '0, -1, 1'b0, 4'b0100);
    run_txn('0, 1, '0, -1, 1'b0, '0);

    for (int n = 0; n < 200; n++) begin
      nr = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      mr = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom_range(0, 15));
      fr = N'($urandom_range(0, 15));
      r  = $urandom_range(0, 19);
      if (r < 14)      hl = r % 4;
      else if (r < 18) hl = $urandom_range(4, 9);
      else             hl = $urandom_range(15, 20);
      run_txn(nr, hl, fr, ($urandom_range(0, 39) == 0) ? $urandom_range(1, 2) : -1,
              1'($urandom_range(0, 1)), mr);
    end
    drain();
    bhold = '0;
    repeat (3) run_txn('0, 0, '0, -1, 1'b0, '0);
    chk("grants_outstanding", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
